// File: rtl/llr_frame_sender_pkg.sv
// Shared definitions for the LLR input stream: default lane count, beat
// arithmetic, end-of-frame bit position and the sender FSM encoding.
package llr_frame_sender_pkg;

    localparam int LANES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Number of LANES-wide beats needed to carry n_v LLRs.
    function automatic int beats_per_frame(input int n_v, input int lanes);
        return (n_v + lanes - 1) / lanes;
    endfunction

    // Index of the end-of-frame flag on the beat bus.
    function automatic int last_bit(input int lanes, input int width);
        return lanes * width;
    endfunction

endpackage

// File: rtl/llr_beat_mux.sv
// Combinational beat selector: picks LANES LLRs of beat k out of a whole
// frame, zero-filling lanes that fall past the end of the frame.
module llr_beat_mux
    import llr_frame_sender_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int N_V    = 44,
    parameter int LANES  = LANES_DEFAULT,
    parameter int BEAT_W = 4
) (
    input  logic [WIDTH*N_V-1:0]   frame,
    input  logic [BEAT_W-1:0]      beat,
    output logic [LANES*WIDTH-1:0] lanes
);

    localparam int DEPTH = 2 ** BEAT_W;

    logic [DEPTH-1:0][LANES-1:0][WIDTH-1:0] beat_table;

    // Table rows beyond the real beats are all padding, so any index is safe.
    for (genvar k = 0; k < DEPTH; k++) begin : g_beat
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            if (k * LANES + j < N_V) begin : g_llr
                assign beat_table[k][j] = frame[WIDTH*(k*LANES+j) +: WIDTH];
            end else begin : g_pad
                assign beat_table[k][j] = '0;
            end
        end
    end

    assign lanes = beat_table[beat];

endmodule

// File: rtl/llr_frame_sender.sv
// Transmit side of the decoder LLR stream: stages one parallel frame and
// serialises it into LANES-wide beats with an end-of-frame flag in the MSB.
module llr_frame_sender
    import llr_frame_sender_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int N_V       = 44,
    parameter int LANES     = LANES_DEFAULT,
    parameter int WAIT_DONE = 1,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    input  logic [WIDTH*N_V-1:0]   frame_llrs,
    input  logic                   dec_done,
    output logic [LANES*WIDTH:0]   llr,
    output logic                   data_valid,
    output logic                   busy,
    output logic [CNT_W-1:0]       frames_sent
);

    localparam int BEATS    = beats_per_frame(N_V, LANES);
    localparam int BEAT_W   = $clog2(BEATS + 1);
    localparam int LAST_BIT = last_bit(LANES, WIDTH);

    state_t                 state;
    state_t                 state_next;
    logic [BEAT_W-1:0]      cnt;
    logic [BEAT_W-1:0]      cnt_next;
    logic [WIDTH*N_V-1:0]   stage;
    logic [WIDTH*N_V-1:0]   active;
    logic                   stage_full;
    logic                   take_stage;
    logic                   sent_inc;
    logic                   valid_next;
    logic [LAST_BIT:0]      llr_next;
    logic [WIDTH*N_V-1:0]   mux_frame;
    logic [BEAT_W-1:0]      mux_beat;
    logic [LAST_BIT-1:0]    mux_lanes;
    logic                   beat_last;

    // In IDLE the first beat comes straight from the staging buffer.
    assign mux_frame = (state == IDLE) ? stage : active;
    assign mux_beat  = (state == IDLE) ? '0 : cnt;
    assign beat_last = (mux_beat == BEAT_W'(BEATS - 1));

    llr_beat_mux #(
        .WIDTH  (WIDTH),
        .N_V    (N_V),
        .LANES  (LANES),
        .BEAT_W (BEAT_W)
    ) u_beat_mux (
        .frame (mux_frame),
        .beat  (mux_beat),
        .lanes (mux_lanes)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        valid_next = 1'b0;
        llr_next   = '0;
        take_stage = 1'b0;
        sent_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (stage_full) begin
                    take_stage = 1'b1;
                    valid_next = 1'b1;
                    llr_next   = {beat_last, mux_lanes};
                    cnt_next   = BEAT_W'(1);
                    state_next = SEND;
                end
            end
            SEND: begin
                if (cnt < BEAT_W'(BEATS)) begin
                    valid_next = 1'b1;
                    llr_next   = {beat_last, mux_lanes};
                    cnt_next   = cnt + BEAT_W'(1);
                end else begin
                    cnt_next   = '0;
                    sent_inc   = 1'b1;
                    state_next = (WAIT_DONE != 0) ? WAIT : IDLE;
                end
            end
            WAIT: begin
                if (dec_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Reset truncates any frame in flight and drops the staged one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            llr         <= '0;
            data_valid  <= 1'b0;
            frames_sent <= '0;
            stage       <= '0;
            stage_full  <= 1'b0;
            active      <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            llr        <= llr_next;
            data_valid <= valid_next;
            if (sent_inc) begin
                frames_sent <= frames_sent + CNT_W'(1);
            end
            if (frame_valid && frame_ready) begin
                stage      <= frame_llrs;
                stage_full <= 1'b1;
            end else if (take_stage) begin
                stage_full <= 1'b0;
            end
            if (take_stage) begin
                active <= stage;
            end
        end
    end

    assign frame_ready = rst & ~stage_full;
    assign busy        = (state != IDLE) | stage_full;

endmodule

// File: tb/tb_llr_frame_sender.sv
// Directed bench for llr_frame_sender: single frame, short last beat,
// WAIT_DONE hand-off, back-to-back frames, reset mid-frame and counter wrap.
module tb_llr_frame_sender;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic          fv_a, fr_a, dd_a, dv_a, busy_a;
    logic [351:0]  fl_a;
    logic [32:0]   llr_a;
    logic [15:0]   fs_a;

    logic          fv_w, fr_w, dd_w, dv_w, busy_w;
    logic [351:0]  fl_w;
    logic [32:0]   llr_w;
    logic [15:0]   fs_w;

    logic          fv_n, fr_n, dd_n, dv_n, busy_n;
    logic [335:0]  fl_n;
    logic [32:0]   llr_n;
    logic [15:0]   fs_n;

    logic          fv_c, fr_c, dd_c, dv_c, busy_c;
    logic [31:0]   fl_c;
    logic [32:0]   llr_c;
    logic [3:0]    fs_c;

    int checks = 0;
    int fails  = 0;

    llr_frame_sender #(.WIDTH(8), .N_V(44), .LANES(4), .WAIT_DONE(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .frame_valid(fv_a), .frame_ready(fr_a), .frame_llrs(fl_a),
        .dec_done(dd_a), .llr(llr_a), .data_valid(dv_a), .busy(busy_a), .frames_sent(fs_a));

    llr_frame_sender #(.WIDTH(8), .N_V(44), .LANES(4), .WAIT_DONE(1), .CNT_W(16)) dut_w (
        .clk(clk), .rst(rst), .frame_valid(fv_w), .frame_ready(fr_w), .frame_llrs(fl_w),
        .dec_done(dd_w), .llr(llr_w), .data_valid(dv_w), .busy(busy_w), .frames_sent(fs_w));

    llr_frame_sender #(.WIDTH(8), .N_V(42), .LANES(4), .WAIT_DONE(0), .CNT_W(16)) dut_n (
        .clk(clk), .rst(rst), .frame_valid(fv_n), .frame_ready(fr_n), .frame_llrs(fl_n),
        .dec_done(dd_n), .llr(llr_n), .data_valid(dv_n), .busy(busy_n), .frames_sent(fs_n));

    llr_frame_sender #(.WIDTH(8), .N_V(4), .LANES(4), .WAIT_DONE(0), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .frame_valid(fv_c), .frame_ready(fr_c), .frame_llrs(fl_c),
        .dec_done(dd_c), .llr(llr_c), .data_valid(dv_c), .busy(busy_c), .frames_sent(fs_c));

    // LLR i of a frame carries the value base+i.
    function automatic logic [351:0] make_frame(input int base);
        logic [351:0] f;
        f = '0;
        for (int i = 0; i < 44; i++) f[8*i +: 8] = 8'(base + i);
        return f;
    endfunction

    // Expected {data_valid, last, lane3..lane0} for beat k.
    function automatic logic [33:0] exp_beat(input int base, input int k, input int n_v, input int nbeats);
        logic [33:0] b;
        b = '0;
        b[33] = 1'b1;
        b[32] = (k == nbeats - 1);
        for (int j = 0; j < 4; j++) begin
            if (4 * k + j < n_v) b[8*j +: 8] = 8'(base + 4 * k + j);
        end
        return b;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [351:0] f;
        rst  = 1'b0;
        fv_a = 1'b0; fv_w = 1'b0; fv_n = 1'b0; fv_c = 1'b0;
        dd_a = 1'b0; dd_w = 1'b0; dd_n = 1'b0; dd_c = 1'b0;
        fl_a = '0;   fl_w = '0;   fl_n = '0;   fl_c = '0;

        repeat (2) @(negedge clk);
        check_output("reset_ready", 64'(fr_a), 64'(0));
        check_output("reset_valid", 64'(dv_a), 64'(0));
        check_output("reset_llr", 64'(llr_a), 64'(0));
        check_output("reset_count", 64'(fs_a), 64'(0));
        check_output("reset_busy", 64'(busy_a), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        check_output("ready_after_reset", 64'(fr_a), 64'(1));

        $display("[TB] single frame, N_V=44 and N_V=42");
        f = make_frame(0);
        fl_a = f; fl_n = f[335:0]; fv_a = 1'b1; fv_n = 1'b1;
        @(negedge clk);
        fv_a = 1'b0; fv_n = 1'b0;
        check_output("accept_ready_drop", 64'(fr_a), 64'(0));
        check_output("no_beat_yet", 64'(dv_a), 64'(0));
        @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            check_output("a_beat", 64'({dv_a, llr_a}), 64'(exp_beat(0, k, 44, 11)));
            check_output("n_beat", 64'({dv_n, llr_n}), 64'(exp_beat(0, k, 42, 11)));
            if (k == 10) begin
                check_output("a_beat10_hand", 64'({dv_a, llr_a}), 64'(34'h3_2B2A2928));
                check_output("n_beat10_hand", 64'({dv_n, llr_n}), 64'(34'h3_00002928));
            end
            @(negedge clk);
        end
        check_output("a_end_valid", 64'(dv_a), 64'(0));
        check_output("a_frames_sent", 64'(fs_a), 64'(1));
        check_output("n_frames_sent", 64'(fs_n), 64'(1));
        check_output("a_idle_busy", 64'(busy_a), 64'(0));

        $display("[TB] back-to-back frames");
        f = make_frame(100); fl_a = f; fv_a = 1'b1;
        @(negedge clk);
        f = make_frame(200); fl_a = f;
        @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            check_output("b2b_first", 64'({dv_a, llr_a}), 64'(exp_beat(100, k, 44, 11)));
            if (k == 1) begin
                fv_a = 1'b0;
                check_output("b2b_staged", 64'(fr_a), 64'(0));
            end
            @(negedge clk);
        end
        check_output("b2b_gap", 64'(dv_a), 64'(0));
        @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            check_output("b2b_second", 64'({dv_a, llr_a}), 64'(exp_beat(200, k, 44, 11)));
            @(negedge clk);
        end
        check_output("b2b_end_valid", 64'(dv_a), 64'(0));
        check_output("b2b_frames_sent", 64'(fs_a), 64'(3));

        $display("[TB] WAIT_DONE hand-off");
        f = make_frame(0); fl_w = f; fv_w = 1'b1;
        @(negedge clk);
        f = make_frame(50); fl_w = f;
        @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            check_output("w_first", 64'({dv_w, llr_w}), 64'(exp_beat(0, k, 44, 11)));
            if (k == 1) begin
                fv_w = 1'b0;
                check_output("w_staged", 64'(fr_w), 64'(0));
            end
            if (k == 3) dd_w = 1'b1;
            if (k == 4) dd_w = 1'b0;
            @(negedge clk);
        end
        check_output("w_end_valid", 64'(dv_w), 64'(0));
        check_output("w_frames_sent", 64'(fs_w), 64'(1));
        check_output("w_busy_waiting", 64'(busy_w), 64'(1));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_output("w_hold", 64'(dv_w), 64'(0));
        end
        dd_w = 1'b1;
        @(negedge clk);
        dd_w = 1'b0;
        check_output("w_idle_cycle", 64'(dv_w), 64'(0));
        @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            check_output("w_second", 64'({dv_w, llr_w}), 64'(exp_beat(50, k, 44, 11)));
            @(negedge clk);
        end
        check_output("w_frames_sent2", 64'(fs_w), 64'(2));

        $display("[TB] frames_sent wrap");
        f = make_frame(0); fl_c = f[31:0]; fv_c = 1'b1;
        @(negedge clk);
        for (int m = 1; m <= 16; m++) begin
            @(negedge clk);
            check_output("c_beat", 64'({dv_c, llr_c}), 64'(34'h3_03020100));
            @(negedge clk);
            check_output("c_count", 64'({dv_c, fs_c}), 64'({1'b0, 4'(m)}));
        end
        fv_c = 1'b0;
        check_output("c_wrapped", 64'(fs_c), 64'(0));

        $display("[TB] reset mid-frame");
        f = make_frame(10); fl_a = f; fv_a = 1'b1;
        @(negedge clk);
        f = make_frame(20); fl_a = f;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            check_output("r_beat", 64'({dv_a, llr_a}), 64'(exp_beat(10, k, 44, 11)));
            if (k == 1) fv_a = 1'b0;
            if (k != 5) @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        check_output("r_valid_cleared", 64'(dv_a), 64'(0));
        check_output("r_llr_cleared", 64'(llr_a), 64'(0));
        check_output("r_ready_forced", 64'(fr_a), 64'(0));
        check_output("r_count_cleared", 64'(fs_a), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("r_ready_after", 64'(fr_a), 64'(1));
        check_output("r_count_after", 64'(fs_a), 64'(0));
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check_output("r_no_beats", 64'({dv_a, busy_a}), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
